// File: rtl/led_strip_hit.sv
// Registered LED strip decoder (dot/bar) with a hit/hold blink state machine.
// Optional score counter enabled by defining LED_STRIP_HIT_SCORE_EN.
`timescale 1ns/1ps
module led_strip_hit #(
  parameter int unsigned LED_NUM   = 10,
  parameter int unsigned CNT_LIM   = 100,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [$clog2(CNT_LIM):0]    cnt_i,
  input  logic [LED_NUM-1:0]          sw_i,
  input  logic                        mode_i,
  input  logic                        hit_i,
  output logic [LED_NUM-1:0]          led_o,
  output logic                        hold_o,
  output logic                        hit_ok_o,
  output logic [$clog2(LED_NUM)-1:0]  hit_idx_o
`ifdef LED_STRIP_HIT_SCORE_EN
  ,
  output logic [$clog2(LED_NUM+1)+3:0] score_o
`endif
);

  localparam int unsigned SEG = CNT_LIM / LED_NUM;
  localparam int unsigned IW  = $clog2(LED_NUM);
  localparam int unsigned BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  if (CNT_LIM % LED_NUM != 0) begin : g_bad_cnt_lim
    $error("CNT_LIM must be a multiple of LED_NUM");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e               state;
  logic [BW-1:0]        blink_cnt;
  logic                 phase_on;

  logic                 in_range;
  logic [31:0]          seg_q;
  logic [IW-1:0]        pos;
  logic [LED_NUM-1:0]   pos_oh;
  logic [LED_NUM-1:0]   bar;
  logic [LED_NUM-1:0]   idx_oh;
  logic [LED_NUM-1:0]   run_led;

  // LED0 owns segment 0; LED i (i > 0) owns segment LED_NUM - i.
  always_comb begin
    seg_q    = 32'(cnt_i) / SEG;
    in_range = (32'(cnt_i) < CNT_LIM);
    pos      = '0;
    if (in_range && seg_q != 0) begin
      pos = IW'(LED_NUM - seg_q);
    end
    pos_oh = '0;
    bar    = '0;
    idx_oh = '0;
    for (int unsigned i = 0; i < LED_NUM; i++) begin
      pos_oh[i] = (32'(pos) == i);
      bar[i]    = (((i == 0) ? 0 : LED_NUM - i) <= seg_q);
      idx_oh[i] = (32'(hit_idx_o) == i);
    end
    run_led = in_range ? ((mode_i ? bar : pos_oh) & sw_i) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= StRun;
      led_o     <= '0;
      hold_o    <= 1'b0;
      hit_ok_o  <= 1'b0;
      hit_idx_o <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
`ifdef LED_STRIP_HIT_SCORE_EN
      score_o   <= '0;
`endif
    end else begin
      unique case (state)
        StRun: begin
          if (hit_i && in_range) begin
            state     <= StHold;
            hit_idx_o <= pos;
            hit_ok_o  <= sw_i[pos];
            hold_o    <= 1'b1;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            led_o     <= pos_oh;
`ifdef LED_STRIP_HIT_SCORE_EN
            if (sw_i[pos] && score_o != '1) begin
              score_o <= score_o + 1'b1;
            end
`endif
          end else begin
            led_o <= run_led;
          end
        end
        StHold: begin
          if (hit_i) begin
            state    <= StRun;
            hold_o   <= 1'b0;
            hit_ok_o <= 1'b0;
            led_o    <= run_led;
          end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            // Output follows the phase that takes effect on this edge.
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
            led_o     <= phase_on ? '0 : idx_oh;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
            led_o     <= phase_on ? idx_oh : '0;
          end
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_hit.sv
// Self-checking bench for led_strip_hit: behavioural model, per-cycle compare, literal spot checks.
`timescale 1ns/1ps
module tb_led_strip_hit;

  localparam int LED  = 10;
  localparam int CLIM = 100;
  localparam int BDIV = 4;
  localparam int SEGW = CLIM / LED;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt;
  logic [9:0] sw;
  logic       mode;
  logic       hit;
  logic [9:0] led;
  logic       hold;
  logic       hit_ok;
  logic [3:0] hit_idx;
`ifdef LED_STRIP_HIT_SCORE_EN
  logic [7:0] score;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  led_strip_hit #(
    .LED_NUM  (LED),
    .CNT_LIM  (CLIM),
    .BLINK_DIV(BDIV)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cnt_i    (cnt),
    .sw_i     (sw),
    .mode_i   (mode),
    .hit_i    (hit),
    .led_o    (led),
    .hold_o   (hold),
    .hit_ok_o (hit_ok),
    .hit_idx_o(hit_idx)
`ifdef LED_STRIP_HIT_SCORE_EN
    ,
    .score_o  (score)
`endif
  );

  always #5 clk = ~clk;

  // Lowest count shown on LED i: LED0 shows 0..9, LED9 10..19, ..., LED1 90..99.
  function automatic int led_lo(int i);
    return ((i == 0) ? 0 : (LED - i)) * SEGW;
  endfunction

  function automatic int led_at(int c);
    for (int i = 0; i < LED; i++) begin
      if (c >= led_lo(i) && c < led_lo(i) + SEGW) return i;
    end
    return -1;
  endfunction

  function automatic logic [9:0] run_decode(int c, logic [9:0] s, logic m);
    logic [9:0] r;
    r = '0;
    if (c < CLIM) begin
      for (int i = 0; i < LED; i++) begin
        if (m) r[i] = (c >= led_lo(i));
        else   r[i] = (c >= led_lo(i)) && (c < led_lo(i) + SEGW);
      end
    end
    return r & s;
  endfunction

  // Model state: expected outputs after each rising edge.
  logic [9:0] m_led;
  bit         m_hold;
  bit         m_ok;
  int         m_idx;
  int         m_age;
  int         m_p;
  int         m_score;

  always @(posedge clk) begin
    if (rst) begin
      m_led = '0; m_hold = 0; m_ok = 0; m_idx = 0; m_age = 0; m_score = 0;
    end else if (!m_hold) begin
      if (hit && int'(cnt) < CLIM) begin
        m_p    = led_at(int'(cnt));
        m_hold = 1;
        m_idx  = m_p;
        m_ok   = sw[m_p];
        m_age  = 0;
        m_led  = '0;
        m_led[m_p] = 1'b1;
        if (m_ok && m_score < 255) m_score++;
      end else begin
        m_led = run_decode(int'(cnt), sw, mode);
      end
    end else if (hit) begin
      m_hold = 0;
      m_ok   = 0;
      m_led  = run_decode(int'(cnt), sw, mode);
    end else begin
      m_age++;
      m_led = '0;
      if ((m_age / BDIV) % 2 == 0) m_led[m_idx] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ({led, hold, hit_ok, hit_idx} !== {m_led, m_hold, m_ok, 4'(m_idx)}) begin
        n_fail++;
        $display("FAIL model t=%0t got led=%b hold=%b ok=%b idx=%0d exp led=%b hold=%b ok=%b idx=%0d",
                 $time, led, hold, hit_ok, hit_idx, m_led, m_hold, m_ok, m_idx);
      end
`ifdef LED_STRIP_HIT_SCORE_EN
      n_tests++;
      if (score !== 8'(m_score)) begin
        n_fail++;
        $display("FAIL score_model t=%0t got %0d exp %0d", $time, score, m_score);
      end
`endif
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hit = 1'b0; cnt = '0; sw = '1; mode = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("reset_led", 32'(led), 0);
    check("reset_flags", {hold, hit_ok, hit_idx}, 0);
    rst = 1'b0;

    // Dot sweep, all enabled.
    for (int c = 0; c < CLIM; c++) begin
      cnt = 8'(c);
      tick(1);
      if (c == 5)  check("dot_5",  32'(led), 32'b0000000001);
      if (c == 15) check("dot_15", 32'(led), 32'b1000000000);
      if (c == 95) check("dot_95", 32'(led), 32'b0000000010);
      tick(1);
    end

    // Single-LED enable sweeps.
    for (int k = 0; k < LED; k++) begin
      sw = 10'(1) << k;
      for (int c = 0; c < CLIM; c++) begin
        cnt = 8'(c);
        tick(1);
        if (k == 3 && c == 75) check("sw3_75", 32'(led), 32'b0000001000);
        if (k == 3 && c == 65) check("sw3_65", 32'(led), 0);
      end
    end

    // Bar mode.
    mode = 1'b1; sw = '1; cnt = 8'd25;
    tick(1);
    check("bar_25", 32'(led), 32'b1100000001);
    sw = 10'b0111111111;
    tick(1);
    check("bar_25_masked", 32'(led), 32'b0100000001);
    cnt = 8'd100;
    tick(1);
    check("bar_100", 32'(led), 0);

    // Successful hit and blinking.
    mode = 1'b0; sw = 10'b0000010000; cnt = 8'd62;
    tick(1);
    pulse_hit();
    check("hit_flags", {hold, hit_ok, hit_idx}, {1'b1, 1'b1, 4'd4});
    check("hit_led", 32'(led), 32'b0000010000);
    cnt = 8'd5;
    tick(3);
    check("blink_on_3", 32'(led), 32'b0000010000);
    tick(1);
    check("blink_off_4", 32'(led), 0);
    tick(3);
    check("blink_off_7", 32'(led), 0);
    tick(1);
    check("blink_on_8", 32'(led), 32'b0000010000);
    check("still_hold", 32'(hold), 1);
    pulse_hit();
    check("exit_hold", 32'(hold), 0);

    // Miss, exit, then reset colliding with hit.
    mode = 1'b1; sw = 10'b1101111111; cnt = 8'd35;
    tick(1);
    pulse_hit();
    check("miss_flags", {hold, hit_ok, hit_idx}, {1'b1, 1'b0, 4'd7});
    check("miss_led", 32'(led), 32'b0010000000);
    pulse_hit();
    check("miss_exit_hold", 32'(hold), 0);
    check("miss_exit_led", 32'(led), 32'b1100000001);
    pulse_hit();
    rst = 1'b1; hit = 1'b1;
    tick(1);
    check("rst_hit_led", 32'(led), 0);
    check("rst_hit_flags", {hold, hit_ok, hit_idx}, 0);
    rst = 1'b0; hit = 1'b0;
    tick(1);
    check("after_rst_run", {hold, led}, {1'b0, 10'b1100000001});

    // Randomised traffic including out-of-range counts and resets.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      hit  = ($urandom_range(0, 15) == 0);
      cnt  = $urandom_range(0, 1) ? 8'($urandom_range(0, 99)) : 8'($urandom_range(0, 255));
      sw   = 10'($urandom);
      mode = 1'($urandom);
      tick(1);
    end
    rst = 1'b0; hit = 1'b0;

`ifdef LED_STRIP_HIT_SCORE_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin sw = '1; cnt = 8'(i * 10 + 3); end
      else       begin sw = '0; cnt = 8'd50; end
      tick(1);
      pulse_hit();
      pulse_hit();
    end
    check("score_3", 32'(score), 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("score_rst", 32'(score), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
